// File: rtl/rou_msg_arb_if.sv
// Message channel bundle shared by the roubus requesters and the round-robin arbiter output.
// Latency: none, this is wiring only.
// Backpressure: in_rdy/out_rdy carry the accept side of each valid/ready pair.
// Ports: in_msg/in_vld/in_rdy   NREQ packed requester messages with handshake
//        out_msg/out_vld/out_rdy registered granted message with handshake
//        out_src/locked          source index of out_msg, burst lock held
interface rou_msg_arb_if #(
   parameter int NREQ = 4,
   parameter int WID  = 171,
   parameter int SWID = $clog2(NREQ)
);
   logic [NREQ*WID-1:0] in_msg;
   logic [NREQ-1:0]     in_vld;
   logic [NREQ-1:0]     in_rdy;
   logic [WID-1:0]      out_msg;
   logic                out_vld;
   logic                out_rdy;
   logic [SWID-1:0]     out_src;
   logic                locked;

   // Environment side: drives requests and the downstream accept.
   modport master (
      output in_msg, in_vld, out_rdy,
      input  in_rdy, out_msg, out_vld, out_src, locked
   );

   // Arbiter side.
   modport slave (
      input  in_msg, in_vld, out_rdy,
      output in_rdy, out_msg, out_vld, out_src, locked
   );
endinterface

// File: rtl/rou_msg_arb.sv
// Round-robin arbiter sharing one roubus message channel among NREQ requesters, with burst lock.
// Latency: 1 cycle, message accepted at edge N is on out_* from edge N; one message per cycle.
// Backpressure: out_vld & !out_rdy holds the output and drops every in_rdy to 0.
// Ports: clk, rst (async, active-high); bus (rou_msg_arb_if.slave):
//        in_msg/in_vld/in_rdy per requester, out_msg/out_vld/out_rdy/out_src, locked.
module rou_msg_arb #(
   parameter int DWID = 128,
   parameter int AWID = 32,
   parameter int TWID = 5,
   parameter int NREQ = 4
) (
   input  logic          clk,
   input  logic          rst,
   rou_msg_arb_if.slave  bus
);
   localparam int BWID = (DWID == 512) ? 6 :
                         (DWID == 256) ? 5 :
                         (DWID == 128) ? 4 :
                         (DWID == 64)  ? 3 : 2;
   localparam int WID  = 2 + DWID + AWID + BWID + TWID;
   localparam int SWID = $clog2(NREQ);

   // cmd code for a burst beat with more beats to follow
   localparam logic [1:0] CMD_MORE = 2'b11;

   logic [WID-1:0]  req_msg [NREQ];

   logic [WID-1:0]  out_msg_q, out_msg_d;
   logic            out_vld_q, out_vld_d;
   logic [SWID-1:0] out_src_q, out_src_d;
   logic            locked_q,  locked_d;
   logic [SWID-1:0] owner_q,   owner_d;
   logic [SWID-1:0] rr_q,      rr_d;

   logic            load;
   logic            gnt_vld;
   logic [SWID-1:0] gnt_idx;
   logic [WID-1:0]  gnt_msg;
   logic [NREQ-1:0] in_rdy_c;
   int              cand;
   logic [SWID-1:0] cand_idx;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_msg[i] = bus.in_msg[i*WID +: WID];
   end

   // Output register is free, or being emptied this cycle.
   assign load = !out_vld_q || bus.out_rdy;

   // Grant search. While locked only the owner may win. Otherwise scan from the
   // rr pointer upward with wrap; the scan runs high-to-low offset so the
   // lowest offset (closest to the pointer) overwrites and wins.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      if (locked_q) begin
         gnt_vld = bus.in_vld[owner_q];
         gnt_idx = owner_q;
      end else begin
         for (int k = NREQ-1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NREQ) begin
               cand = cand - NREQ;
            end
            cand_idx = SWID'(cand);
            if (bus.in_vld[cand_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand_idx;
            end
         end
      end
   end

   assign gnt_msg = req_msg[gnt_idx];

   // Ready is gated by rst so nothing is accepted while reset is asserted.
   always_comb begin
      in_rdy_c = '0;
      if (!rst && load && gnt_vld) begin
         in_rdy_c[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      out_msg_d = out_msg_q;
      out_vld_d = out_vld_q;
      out_src_d = out_src_q;
      locked_d  = locked_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      if (load) begin
         if (gnt_vld) begin
            out_msg_d = gnt_msg;
            out_src_d = gnt_idx;
            out_vld_d = 1'b1;
            if (gnt_msg[1:0] == CMD_MORE) begin
               // Burst continues: pin the channel to this requester, pointer stays.
               locked_d = 1'b1;
               owner_d  = gnt_idx;
            end else begin
               locked_d = 1'b0;
               rr_d     = (gnt_idx == SWID'(NREQ-1)) ? '0 : gnt_idx + SWID'(1);
            end
         end else begin
            // Nothing eligible: drain. Message and source hold their last values.
            out_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_msg_q <= '0;
         out_vld_q <= 1'b0;
         out_src_q <= '0;
         locked_q  <= 1'b0;
         owner_q   <= '0;
         rr_q      <= '0;
      end else begin
         out_msg_q <= out_msg_d;
         out_vld_q <= out_vld_d;
         out_src_q <= out_src_d;
         locked_q  <= locked_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
      end
   end

   assign bus.in_rdy  = in_rdy_c;
   assign bus.out_msg = out_msg_q;
   assign bus.out_vld = out_vld_q;
   assign bus.out_src = out_src_q;
   assign bus.locked  = locked_q;
endmodule

// File: tb/tb_rou_msg_arb.sv
// Bench for rou_msg_arb: directed scenarios plus a randomized run, checked against a queue-free
// transaction-level model of the arbitration rules (pointer, lock owner, output register).
// Inputs change 1 time unit after the rising edge; in_rdy is compared at the falling edge.
module tb_rou_msg_arb;
   localparam int NREQ = 4;
   localparam int DWID = 128;
   localparam int AWID = 32;
   localparam int TWID = 5;
   localparam int BWID = 4;
   localparam int WID  = 2 + DWID + AWID + BWID + TWID;
   localparam int SWID = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rou_msg_arb_if #(.NREQ(NREQ), .WID(WID), .SWID(SWID)) bus ();

   rou_msg_arb #(.DWID(DWID), .AWID(AWID), .TWID(TWID), .NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WID-1:0]  req_msg [NREQ];
   logic [NREQ-1:0] req_vld;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
      assign bus.in_msg[gi*WID +: WID] = req_msg[gi];
   end
   assign bus.in_vld = req_vld;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int              m_rr, m_owner, m_src;
   bit              m_locked, m_vld;
   logic [WID-1:0]  m_msg;
   logic [NREQ-1:0] exp_rdy;

   function automatic logic [WID-1:0] make_msg(input logic [1:0] cmd);
      logic [191:0]   r;
      logic [WID-1:0] m;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      m = r[WID-1:0];
      m[1:0] = cmd;
      return m;
   endfunction

   task automatic model_reset();
      m_rr = 0; m_owner = 0; m_src = 0;
      m_locked = 0; m_vld = 0; m_msg = '0;
      exp_rdy = '0;
   endtask

   // Which requester should be accepted this cycle, from the rules.
   task automatic predict();
      exp_rdy = '0;
      if (!rst && (!m_vld || bus.out_rdy)) begin
         if (m_locked) begin
            if (req_vld[m_owner]) exp_rdy[m_owner] = 1'b1;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               if (req_vld[(m_rr + k) % NREQ]) begin
                  exp_rdy[(m_rr + k) % NREQ] = 1'b1;
                  break;
               end
            end
         end
      end
   endtask

   // Advance the model by one transfer decision and move to 1 unit after the next edge.
   task automatic tick();
      int g;
      predict();
      if (exp_rdy != '0) begin
         g = 0;
         for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
         m_msg = req_msg[g];
         m_src = g;
         m_vld = 1;
         if (req_msg[g][1:0] == 2'b11) begin
            m_locked = 1; m_owner = g;
         end else begin
            m_locked = 0; m_rr = (g + 1) % NREQ;
         end
      end else if (!m_vld || bus.out_rdy) begin
         m_vld = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_vld = '0;
      bus.out_rdy = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_rdy = 1'b1;
      for (int i = 0; i < NREQ; i++) req_msg[i] = make_msg(2'b01);
      req_vld = '1;
      model_reset();
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.in_rdy !== 4'b0000) begin
         errors++; $display("FAIL reset_rdy: got %b want 0000", bus.in_rdy);
      end
      checks++;
      if (bus.out_vld !== 1'b0 || bus.locked !== 1'b0 || bus.out_src !== 2'd0 || bus.out_msg !== '0) begin
         errors++;
         $display("FAIL reset_out: got vld=%b lck=%b src=%0d msg=%h want all zero",
                  bus.out_vld, bus.locked, bus.out_src, bus.out_msg);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      predict();
      checks++;
      if (bus.in_rdy !== 4'b0001 || bus.in_rdy !== exp_rdy) begin
         errors++; $display("FAIL reset_first_gnt: got %b want 0001", bus.in_rdy);
      end
      tick();
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_src !== 2'd0 || bus.out_msg !== m_msg) begin
         errors++;
         $display("FAIL reset_first_out: got vld=%b src=%0d msg=%h want vld=1 src=0 msg=%h",
                  bus.out_vld, bus.out_src, bus.out_msg, m_msg);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < NREQ; i++) req_msg[i] = make_msg(2'b01);
      req_vld = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         predict();
         checks++;
         if (bus.in_rdy !== exp_rdy) begin
            errors++; $display("FAIL fair_rdy c%0d: got %b want %b", c, bus.in_rdy, exp_rdy);
         end
         tick();
         checks++;
         if (bus.out_vld !== 1'b1 || bus.out_src !== SWID'(c % NREQ) || bus.out_msg !== m_msg) begin
            errors++;
            $display("FAIL fair_out c%0d: got vld=%b src=%0d want vld=1 src=%0d",
                     c, bus.out_vld, bus.out_src, c % NREQ);
         end
         for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) req_msg[i] = make_msg(2'b01);
      end
   endtask

   task automatic test_backpressure();
      logic [WID-1:0]  held_msg;
      logic [SWID-1:0] held_src;
      bus.out_rdy = 1'b1;
      req_vld = '1;
      @(negedge clk);
      tick();
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) req_msg[i] = make_msg(2'b01);
      held_msg = m_msg;
      held_src = SWID'(m_src);
      bus.out_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.in_rdy !== 4'b0000) begin
            errors++; $display("FAIL bp_rdy c%0d: got %b want 0000", c, bus.in_rdy);
         end
         tick();
         checks++;
         if (bus.out_vld !== 1'b1 || bus.out_src !== held_src || bus.out_msg !== held_msg) begin
            errors++;
            $display("FAIL bp_hold c%0d: got vld=%b src=%0d want vld=1 src=%0d",
                     c, bus.out_vld, bus.out_src, held_src);
         end
      end
      bus.out_rdy = 1'b1;
      @(negedge clk);
      tick();
      checks++;
      if (bus.out_src !== held_src + SWID'(1) || bus.out_msg !== m_msg) begin
         errors++;
         $display("FAIL bp_next: got src=%0d want %0d", bus.out_src, held_src + SWID'(1));
      end
   endtask

   task automatic test_burst_lock();
      int exp_src [7] = '{2, 2, 2, 2, 2, 3, 0};
      bit exp_vld [7] = '{1, 0, 0, 1, 1, 1, 1};
      bit exp_lck [7] = '{1, 1, 1, 1, 0, 0, 0};
      bit r2_vld  [7] = '{1, 0, 0, 1, 1, 0, 0};
      bus.out_rdy = 1'b1;
      // Single message from req1 places the pointer at 2.
      req_vld = 4'b0010;
      req_msg[1] = make_msg(2'b01);
      @(negedge clk);
      tick();
      req_vld = 4'b1001;
      req_msg[0] = make_msg(2'b01);
      req_msg[3] = make_msg(2'b01);
      for (int c = 0; c < 7; c++) begin
         req_vld[2] = r2_vld[c];
         req_msg[2] = make_msg((c == 4) ? 2'b01 : 2'b11);
         @(negedge clk);
         predict();
         checks++;
         if (bus.in_rdy !== exp_rdy) begin
            errors++; $display("FAIL burst_rdy c%0d: got %b want %b", c, bus.in_rdy, exp_rdy);
         end
         tick();
         checks++;
         if (bus.out_vld !== exp_vld[c] || bus.out_src !== SWID'(exp_src[c]) || bus.locked !== exp_lck[c]
             || bus.out_msg !== m_msg) begin
            errors++;
            $display("FAIL burst_out c%0d: got vld=%b src=%0d lck=%b want vld=%b src=%0d lck=%b",
                     c, bus.out_vld, bus.out_src, bus.locked, exp_vld[c], exp_src[c], exp_lck[c]);
         end
         if (exp_rdy[0]) req_vld[0] = 1'b0;
         if (exp_rdy[3]) req_vld[3] = 1'b0;
      end
   endtask

   task automatic test_wrap_idle();
      logic [NREQ-1:0] pat [3] = '{4'b1000, 4'b0001, 4'b0000};
      int              src [3] = '{3, 0, 0};
      bit              vld [3] = '{1, 1, 0};
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req_vld = pat[c];
         for (int i = 0; i < NREQ; i++) req_msg[i] = make_msg(2'b10);
         @(negedge clk);
         tick();
         checks++;
         if (bus.out_vld !== vld[c] || bus.out_src !== SWID'(src[c]) || bus.out_msg !== m_msg) begin
            errors++;
            $display("FAIL wrap_out c%0d: got vld=%b src=%0d want vld=%b src=%0d",
                     c, bus.out_vld, bus.out_src, vld[c], src[c]);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.out_rdy = 1'b1;
      req_vld = 4'b0010;
      req_msg[1] = make_msg(2'b11);
      @(negedge clk);
      tick();
      checks++;
      if (bus.locked !== 1'b1 || bus.out_src !== 2'd1) begin
         errors++; $display("FAIL areset_pre: got lck=%b src=%0d want lck=1 src=1", bus.locked, bus.out_src);
      end
      req_msg[1] = make_msg(2'b11);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.locked !== 1'b0 || bus.out_vld !== 1'b0 || bus.in_rdy !== 4'b0000) begin
         errors++;
         $display("FAIL areset_now: got lck=%b vld=%b rdy=%b want 0 0 0000", bus.locked, bus.out_vld, bus.in_rdy);
      end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      req_vld = '1;
      for (int i = 0; i < NREQ; i++) req_msg[i] = make_msg(2'b01);
      @(negedge clk);
      checks++;
      if (bus.in_rdy !== 4'b0001) begin
         errors++; $display("FAIL areset_ptr: got %b want 0001", bus.in_rdy);
      end
      tick();
      req_vld = '0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.out_rdy = ($urandom_range(3, 0) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_vld[i] && $urandom_range(1, 0) == 1) begin
               req_msg[i] = make_msg(2'($urandom_range(3, 0)));
               req_vld[i] = 1'b1;
            end
         end
         @(negedge clk);
         predict();
         checks++;
         if (bus.in_rdy !== exp_rdy) begin
            errors++; $display("FAIL rand_rdy c%0d: got %b want %b", c, bus.in_rdy, exp_rdy);
         end
         tick();
         checks++;
         if (bus.out_vld !== m_vld || bus.out_src !== SWID'(m_src) || bus.locked !== m_locked
             || bus.out_msg !== m_msg) begin
            errors++;
            $display("FAIL rand_out c%0d: got vld=%b src=%0d lck=%b want vld=%b src=%0d lck=%b",
                     c, bus.out_vld, bus.out_src, bus.locked, m_vld, m_src, m_locked);
         end
         for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) req_vld[i] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      req_vld = '0;
      bus.out_rdy = 1'b0;
      for (int i = 0; i < NREQ; i++) req_msg[i] = '0;
      model_reset();
      #1;
      test_reset();
      test_fairness();
      test_backpressure();
      test_burst_lock();
      test_wrap_idle();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
